// File: rtl/sr_cmd_seq.sv
// Command sequencer for an sr_ff: buffers HOLD/CLEAR/SET/TOGGLE commands, issues each
// as a one-cycle s/r pulse plus a settle cycle, and checks q/qb against a shadow model.
module sr_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd,
    input  logic             q,
    input  logic             qb,
    output logic             s,
    output logic             r,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] CMD_HOLD   = 2'b00;
    localparam logic [1:0] CMD_CLEAR  = 2'b01;
    localparam logic [1:0] CMD_SET    = 2'b10;
    localparam logic [1:0] CMD_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SETTLE
    } state_t;

    state_t state, state_nxt;

    logic [1:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [1:0]  head;
    logic [1:0]  cur_cmd;
    logic        empty, full, push, pop;
    logic        s_nxt, r_nxt;
    logic        mismatch;

    // Extra pointer bit separates full from empty when the index bits match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign busy      = (state != IDLE) || !empty;
    assign mismatch  = (q != exp_q) || (qb != ~q);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        case (state)
            IDLE, SETTLE: begin
                if (!empty) begin
                    state_nxt = DRIVE;
                    pop       = 1'b1;
                    s_nxt     = head[1];
                    r_nxt     = head[0];
                end else begin
                    state_nxt = IDLE;
                end
            end
            DRIVE:   state_nxt = SETTLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // s/r are registered so sr_ff sees clean pulses; cur_cmd remembers what was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s       <= 1'b0;
            r       <= 1'b0;
            cur_cmd <= CMD_HOLD;
        end else begin
            s <= s_nxt;
            r <= r_nxt;
            if (pop) begin
                cur_cmd <= head;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q     <= 1'b0;
            exp_valid <= 1'b0;
        end else if (state == DRIVE) begin
            case (cur_cmd)
                CMD_SET: begin
                    exp_q     <= 1'b1;
                    exp_valid <= 1'b1;
                end
                CMD_CLEAR: begin
                    exp_q     <= 1'b0;
                    exp_valid <= 1'b1;
                end
                CMD_TOGGLE: exp_q <= ~exp_q;
                default: ;
            endcase
        end
    end

    // q is only trusted once a SET or CLEAR has given the flop a known value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= 1'b0;
            if (state == SETTLE && exp_valid && mismatch) begin
                err <= 1'b1;
                if (err_cnt != {CNT_W{1'b1}}) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sr_cmd_seq.sv
// Self-checking bench for sr_cmd_seq: schedule-based reference model compared every cycle,
// plus directed literal checks of the documented scenarios.
module tb_sr_cmd_seq;

    localparam int DEPTH  = 4;
    localparam int CNT_W  = 2;
    localparam int HIST_N = 8192;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd = 2'b00;
    logic             q, qb;
    logic             s, r, cmd_ready, exp_q, exp_valid, busy, err;
    logic [CNT_W-1:0] err_cnt;

    int total = 0;
    int bad   = 0;

    bit ff_q;
    bit force_q0     = 1'b0;
    bit force_qb_bad = 1'b0;

    always #5 clk = ~clk;

    sr_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .q         (q),
        .qb        (qb),
        .s         (s),
        .r         (r),
        .exp_q     (exp_q),
        .exp_valid (exp_valid),
        .busy      (busy),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    // Stand-in for sr_ff: no reset, starts at an arbitrary value, s=r=1 toggles.
    initial begin
        ff_q = 1'($urandom_range(1, 0));
        forever begin
            @(posedge clk);
            case ({s, r})
                2'b10:   ff_q <= 1'b1;
                2'b01:   ff_q <= 1'b0;
                2'b11:   ff_q <= ~ff_q;
                default: ;
            endcase
        end
    end

    assign q  = force_q0 ? 1'b0 : ff_q;
    assign qb = force_qb_bad ? q : ~q;

    // Reference model: each accepted command gets an accept edge a and a pop edge
    // p = max(a+1, previous p + 2). Every output is derived from these schedules.
    int       rec_a[$];
    int       rec_p[$];
    bit [1:0] rec_c[$];
    int       edge_k;
    int       last_p;
    int       new_p;
    bit       q_hist [HIST_N];
    bit       qb_hist[HIST_N];

    function automatic int occ(input int k);
        int n = 0;
        foreach (rec_a[i]) begin
            if (rec_a[i] <= k && k < rec_p[i]) n++;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_a.delete();
            rec_p.delete();
            rec_c.delete();
            edge_k = 0;
            last_p = -10;
        end else begin
            edge_k = edge_k + 1;
            if (cmd_valid && occ(edge_k - 1) < DEPTH) begin
                new_p = (edge_k + 1 > last_p + 2) ? edge_k + 1 : last_p + 2;
                last_p = new_p;
                rec_a.push_back(edge_k);
                rec_p.push_back(new_p);
                rec_c.push_back(cmd);
            end
        end
    end

    task automatic check_output(input string name, input logic act, input logic expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b at t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic check_count(input string name, input logic [CNT_W-1:0] act,
                               input logic [CNT_W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
        end
    endtask

    int m_k, m_cnt, m_max;
    bit m_s, m_r, m_busy, m_ready, m_eq, m_ev, m_err, m_mis;

    always @(negedge clk) begin
        if (rst_n) begin
            m_k = edge_k;
            if (m_k < HIST_N) begin
                q_hist[m_k]  = q;
                qb_hist[m_k] = qb;
            end
            m_s = 0; m_r = 0; m_busy = 0; m_eq = 0; m_ev = 0; m_err = 0; m_cnt = 0;
            m_max = (1 << CNT_W) - 1;
            foreach (rec_a[i]) begin
                if (rec_p[i] == m_k) {m_s, m_r} = rec_c[i];
                if (rec_a[i] <= m_k && m_k < rec_p[i] + 2) m_busy = 1;
                if (rec_p[i] + 1 <= m_k) begin
                    case (rec_c[i])
                        2'b10: begin m_eq = 1; m_ev = 1; end
                        2'b01: begin m_eq = 0; m_ev = 1; end
                        2'b11: m_eq = !m_eq;
                        default: ;
                    endcase
                end
                if (rec_p[i] + 2 <= m_k && m_ev) begin
                    m_mis = (q_hist[rec_p[i] + 1] != m_eq) ||
                            (qb_hist[rec_p[i] + 1] == q_hist[rec_p[i] + 1]);
                    if (m_mis) begin
                        if (rec_p[i] + 2 == m_k) m_err = 1;
                        if (m_cnt < m_max) m_cnt++;
                    end
                end
            end
            m_ready = occ(m_k) < DEPTH;
            check_output("s", s, m_s);
            check_output("r", r, m_r);
            check_output("cmd_ready", cmd_ready, m_ready);
            check_output("busy", busy, m_busy);
            check_output("exp_q", exp_q, m_eq);
            check_output("exp_valid", exp_valid, m_ev);
            check_output("err", err, m_err);
            check_count("err_cnt", err_cnt, CNT_W'(m_cnt));
        end
    end

    task automatic reset_dut();
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        force_q0     = 1'b0;
        force_qb_bad = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // SET then CLEAR, with reset values checked first
        reset_dut();
        @(negedge clk);
        check_output("rst_s", s, 1'b0);
        check_output("rst_r", r, 1'b0);
        check_output("rst_ready", cmd_ready, 1'b1);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_exp_valid", exp_valid, 1'b0);
        check_count("rst_err_cnt", err_cnt, 2'd0);
        apply_stimulus(2'b10);
        apply_stimulus(2'b01);
        @(negedge clk);
        check_output("set_s", s, 1'b1);
        check_output("set_r", r, 1'b0);
        @(negedge clk);
        check_output("settle_s", s, 1'b0);
        check_output("set_exp_q", exp_q, 1'b1);
        check_output("set_exp_valid", exp_valid, 1'b1);
        @(negedge clk);
        check_output("clear_r", r, 1'b1);
        check_output("clear_s", s, 1'b0);
        @(negedge clk);
        check_output("clear_exp_q", exp_q, 1'b0);
        idle(4);
        check_count("setclr_err_cnt", err_cnt, 2'd0);

        // TOGGLE twice with the flop state still unknown
        reset_dut();
        apply_stimulus(2'b11);
        apply_stimulus(2'b11);
        @(negedge clk);
        check_output("tog1_s", s, 1'b1);
        check_output("tog1_r", r, 1'b1);
        @(negedge clk);
        check_output("tog_gap_s", s, 1'b0);
        @(negedge clk);
        check_output("tog2_s", s, 1'b1);
        check_output("tog2_r", r, 1'b1);
        idle(6);
        check_output("tog_exp_valid", exp_valid, 1'b0);
        check_count("tog_err_cnt", err_cnt, 2'd0);

        // SET, TOGGLE x3, HOLD
        reset_dut();
        apply_stimulus(2'b10);
        apply_stimulus(2'b11);
        apply_stimulus(2'b11);
        apply_stimulus(2'b11);
        apply_stimulus(2'b00);
        idle(14);
        check_output("seq_exp_q", exp_q, 1'b0);
        check_output("seq_exp_valid", exp_valid, 1'b1);
        check_count("seq_err_cnt", err_cnt, 2'd0);

        // Hold cmd_valid high until the FIFO fills
        reset_dut();
        cmd_valid = 1'b1;
        cmd = 2'($urandom);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1 cmd = 2'($urandom);
            @(negedge clk);
            if (i == 7) begin
                check_output("full_ready", cmd_ready, 1'b0);
                check_output("full_busy", busy, 1'b1);
            end
            if (i == 8) check_output("after_pop_ready", cmd_ready, 1'b1);
        end
        cmd_valid = 1'b0;
        idle(24);
        check_output("drain_busy", busy, 1'b0);

        // Forced q=0 after SET: one err pulse, then saturation with CNT_W=2
        reset_dut();
        force_q0 = 1'b1;
        apply_stimulus(2'b10);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_output("force_no_err_yet", err, 1'b0);
        @(negedge clk);
        check_output("force_err", err, 1'b1);
        check_count("force_cnt1", err_cnt, 2'd1);
        @(negedge clk);
        check_output("force_err_drop", err, 1'b0);
        for (int i = 0; i < 4; i++) apply_stimulus(2'b10);
        idle(12);
        check_count("force_cnt_sat", err_cnt, 2'd3);

        // qb not complementary
        reset_dut();
        force_qb_bad = 1'b1;
        apply_stimulus(2'b01);
        idle(6);
        check_count("qb_err_cnt", err_cnt, 2'd1);

        // Random traffic
        reset_dut();
        for (int i = 0; i < 500; i++) begin
            cmd_valid = ($urandom_range(2, 0) != 0);
            cmd = 2'($urandom);
            if ($urandom_range(29, 0) == 0) force_q0 = ~force_q0;
            if ($urandom_range(59, 0) == 0) force_qb_bad = ~force_qb_bad;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        force_q0 = 1'b0;
        force_qb_bad = 1'b0;
        idle(14);

        // Reset asserted during DRIVE with three commands queued
        reset_dut();
        cmd = 2'b10;
        cmd_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check_output("pre_rst_s", s, 1'b1);
        check_output("pre_rst_exp_valid", exp_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_output("midrst_s", s, 1'b0);
        check_output("midrst_r", r, 1'b0);
        check_output("midrst_ready", cmd_ready, 1'b1);
        check_output("midrst_busy", busy, 1'b0);
        check_output("midrst_exp_valid", exp_valid, 1'b0);
        check_count("midrst_err_cnt", err_cnt, 2'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_output("post_rst_s", s, 1'b0);
            check_output("post_rst_busy", busy, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
